// File: rtl/mul_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring on magnitudes) unit.
// Both operations take the same fixed latency; ZHI/ZLO update only on entry to DONE.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ZHI,
    output logic [WIDTH-1:0] ZLO
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic             op_q, sa_q, sb_q, bz_q;
    logic [WIDTH-1:0] a_q, m_q;
    // Multiply layout {P, Q, q_-1}; divide layout {R (WIDTH+1 bits), Q}.
    logic [2*WIDTH:0] acc;

    logic [WIDTH-1:0] amag, bmag;
    logic [WIDTH:0]   p_ext, m_ext, bsum, shifted;
    logic [WIDTH+1:0] diff;
    logic [2*WIDTH:0] mul_nx, div_nx;
    logic [WIDTH-1:0] quo, rem, res_hi, res_lo;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (cnt == LAST) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        amag = A[WIDTH-1] ? -A : A;
        bmag = B[WIDTH-1] ? -B : B;

        // Booth add/subtract is done one bit wider so a most-negative multiplicand cannot overflow.
        p_ext = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
        m_ext = {m_q[WIDTH-1], m_q};
        bsum  = p_ext;
        if (acc[1:0] == 2'b01)      bsum = p_ext + m_ext;
        else if (acc[1:0] == 2'b10) bsum = p_ext - m_ext;
        mul_nx = {bsum, acc[WIDTH:1]};

        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, m_q};
        div_nx  = {(diff[WIDTH+1] ? shifted : diff[WIDTH:0]), acc[WIDTH-2:0], ~diff[WIDTH+1]};

        quo    = acc[WIDTH-1:0];
        rem    = acc[2*WIDTH-1:WIDTH];
        res_hi = acc[2*WIDTH:WIDTH+1];
        res_lo = acc[WIDTH:1];
        if (op_q) begin
            if (bz_q) begin
                res_lo = '1;
                res_hi = a_q;
            end else begin
                res_lo = (sa_q ^ sb_q) ? -quo : quo;
                res_hi = sa_q ? -rem : rem;
            end
        end
    end

    // NOTE: the datapath registers are reset along with the control state, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 1'b0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            bz_q  <= 1'b0;
            a_q   <= '0;
            m_q   <= '0;
            acc   <= '0;
            ZHI   <= '0;
            ZLO   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        a_q  <= A;
                        sa_q <= A[WIDTH-1];
                        sb_q <= B[WIDTH-1];
                        bz_q <= (B == '0);
                        cnt  <= '0;
                        if (op) begin
                            m_q <= bmag;
                            acc <= {{(WIDTH+1){1'b0}}, amag};
                        end else begin
                            m_q <= A;
                            acc <= {{WIDTH{1'b0}}, B, 1'b0};
                        end
                    end
                end
                RUN: begin
                    // The final RUN cycle (cnt == WIDTH) only hands over to FIX.
                    if (cnt != LAST) begin
                        acc <= op_q ? div_nx : mul_nx;
                        cnt <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    ZHI <= res_hi;
                    ZLO <= res_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (WIDTH=32): results, latency, busy/hold,
// start-while-busy, back-to-back start, and asynchronous reset mid-operation.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] ZHI;
    logic [31:0] ZLO;

    int errors = 0;
    int checks = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .ZHI   (ZHI),
        .ZLO   (ZLO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // mode 0: plain; mode 1: start with new operands mid-RUN; mode 2: start held during DONE.
    task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int mode);
        int          lat;
        logic        busy_ok;
        logic        hold_ok;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        prev_hi = ZHI;
        prev_lo = ZLO;
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (mode == 1 && k == 9) begin
                start = 1'b1;
                op    = ~o;
                A     = 32'h0000_0001;
                B     = 32'h0000_0001;
            end
            if (mode == 1 && k == 10) start = 1'b0;
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (ZHI !== prev_hi || ZLO !== prev_lo) hold_ok = 1'b0;
        end
        check({tag, " latency"}, lat, 34);
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " hold"}, {31'd0, hold_ok}, 32'd1);
        check({tag, " ZHI"}, ZHI, exp_hi);
        check({tag, " ZLO"}, ZLO, exp_lo);
        if (mode == 2) begin
            start = 1'b1;
            op    = 1'b0;
            A     = 32'd9;
            B     = 32'd9;
        end
        @(posedge clk); #1;
        check({tag, " idle after"}, {30'd0, busy, done}, 32'd0);
        if (mode == 2) begin
            start = 1'b0;
            check({tag, " ZLO held"}, ZLO, exp_lo);
        end
    endtask

    initial begin
        int stray;
        clr   = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        A     = '0;
        B     = '0;
        @(posedge clk); #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset ZHI", ZHI, 32'd0);
        check("reset ZLO", ZLO, 32'd0);
        #2 clr = 1'b1;
        @(posedge clk); #1;

        run_op("mul 7*-3",       1'b0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        run_op("mul min*min",    1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        run_op("mul max*max",    1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0);
        run_op("mul -1*min",     1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("div -17/5",      1'b1, 32'hFFFF_FFEF, 32'd5,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        run_op("div by zero",    1'b1, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 0);
        run_op("div overflow",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("div 100/-7",     1'b1, 32'd100,      32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 0);
        run_op("busy start",     1'b0, 32'd6,        32'd7,        32'h0000_0000, 32'h0000_002A, 1);
        run_op("div -100/-7 b2b", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 2);

        // Abort a multiply with an asynchronous reset partway through RUN.
        op    = 1'b0;
        A     = 32'd5;
        B     = 32'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1 clr = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort ZHI", ZHI, 32'd0);
        check("abort ZLO", ZLO, 32'd0);
        #2 clr = 1'b1;
        stray = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) stray++;
        end
        check("abort no result", stray, 32'd0);

        run_op("mul 3*4",        1'b0, 32'd3,        32'd4,        32'h0000_0000, 32'h0000_000C, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
